// File: rtl/conv2_pkg.sv
// Shared types and sizing helpers for the conv2 box-sum convolution core.
// CONV2_SATURATE_EN selects saturating instead of wrapping result reduction.
package conv2_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      DONE = 1'b1
   } state_e;

   function automatic int unsigned out_size(input int unsigned size, input int unsigned size_ker);
      return size - size_ker + 1;
   endfunction

   function automatic int unsigned acc_width(input int unsigned width_bit, input int unsigned size_ker);
      return width_bit + $clog2(size_ker * size_ker);
   endfunction

   // Reduce a full-width window sum to w bits (w < 32).
   function automatic logic [31:0] sat_or_wrap(input logic [31:0] sum, input int unsigned w);
      logic [31:0] max_v;
      max_v = (32'd1 << w) - 32'd1;
`ifdef CONV2_SATURATE_EN
      return (sum > max_v) ? max_v : sum;
`else
      return sum & max_v;
`endif
   endfunction

endpackage

// File: rtl/conv2_if.sv
// Matrix bus between the pixel source (master) and the conv2 core (slave).
interface conv2_if
   import conv2_pkg::*;
#(
   parameter int unsigned SIZE      = 7,
   parameter int unsigned SIZEKer   = 3,
   parameter int unsigned WIDTH_BIT = 8
);
   localparam int unsigned OUT = out_size(SIZE, SIZEKer);

   logic [WIDTH_BIT-1:0] inpMatrixI      [SIZE-1:0][SIZE-1:0];
   logic                 done;
   logic [WIDTH_BIT-1:0] convIxKernelOut [OUT-1:0][OUT-1:0];

   modport master (output inpMatrixI, input done, input convIxKernelOut);
   modport slave  (input inpMatrixI, output done, output convIxKernelOut);
endinterface

// File: rtl/conv2_window_sum.sv
// Combinational full-width sum of one SIZEKer x SIZEKer window.
module conv2_window_sum
   import conv2_pkg::*;
#(
   parameter int unsigned SIZEKer   = 3,
   parameter int unsigned WIDTH_BIT = 8,
   parameter int unsigned ACC_W     = acc_width(WIDTH_BIT, SIZEKer)
) (
   input  logic [WIDTH_BIT-1:0] win_i [SIZEKer][SIZEKer],
   output logic [ACC_W-1:0]     sum_c_o
);

   always_comb begin
      sum_c_o = '0;
      for (int unsigned i = 0; i < SIZEKer; i++) begin
         for (int unsigned j = 0; j < SIZEKer; j++) begin
            sum_c_o = sum_c_o + ACC_W'(win_i[i][j]);
         end
      end
   end

endmodule

// File: rtl/conv2_core.sv
// Sequential valid-mode 2-D box-sum convolution, one output element per clock.
// Build option: CONV2_SATURATE_EN (saturate instead of wrap on overflow).
module conv2_core
   import conv2_pkg::*;
#(
   parameter int unsigned SIZE      = 7,
   parameter int unsigned SIZEKer   = 3,
   parameter int unsigned WIDTH_BIT = 8
) (
   input  logic    clock,
   input  logic    nreset,
   conv2_if.slave  bus
);

   localparam int unsigned OUT    = out_size(SIZE, SIZEKer);
   localparam int unsigned ACC_W  = acc_width(WIDTH_BIT, SIZEKer);
   localparam int unsigned OIDX_W = (OUT > 1) ? $clog2(OUT) : 1;
   localparam int unsigned SIDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [OIDX_W-1:0] LAST = OIDX_W'(OUT - 1);

   state_e              state_q;
   logic [OIDX_W-1:0]   r_q;
   logic [OIDX_W-1:0]   c_q;

   logic [WIDTH_BIT-1:0] win_c [SIZEKer][SIZEKer];
   logic [ACC_W-1:0]     sum_c;
   logic [WIDTH_BIT-1:0] elem_c;

   // Window slice anchored at the current output index, taken from the live input.
   always_comb begin
      for (int unsigned i = 0; i < SIZEKer; i++) begin
         for (int unsigned j = 0; j < SIZEKer; j++) begin
            win_c[i][j] = bus.inpMatrixI[SIDX_W'(r_q) + SIDX_W'(i)][SIDX_W'(c_q) + SIDX_W'(j)];
         end
      end
   end

   conv2_window_sum #(
      .SIZEKer   (SIZEKer),
      .WIDTH_BIT (WIDTH_BIT),
      .ACC_W     (ACC_W)
   ) u_window_sum (
      .win_i   (win_c),
      .sum_c_o (sum_c)
   );

   assign elem_c = WIDTH_BIT'(sat_or_wrap(32'(sum_c), WIDTH_BIT));

   // Raster walk over the output matrix; the final write parks the FSM in DONE.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state_q  <= RUN;
         r_q      <= '0;
         c_q      <= '0;
         bus.done <= 1'b0;
         for (int unsigned i = 0; i < OUT; i++) begin
            for (int unsigned j = 0; j < OUT; j++) begin
               bus.convIxKernelOut[OIDX_W'(i)][OIDX_W'(j)] <= '0;
            end
         end
      end else begin
         case (state_q)
            RUN: begin
               bus.convIxKernelOut[r_q][c_q] <= elem_c;
               if (c_q == LAST) begin
                  if (r_q == LAST) begin
                     state_q  <= DONE;
                     bus.done <= 1'b1;
                  end else begin
                     c_q <= '0;
                     r_q <= r_q + OIDX_W'(1);
                  end
               end else begin
                  c_q <= c_q + OIDX_W'(1);
               end
            end
            DONE: begin
               state_q <= DONE;
            end
            default: begin
               state_q <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv2_core.sv
// Directed self-checking bench for conv2_core (7x7 input, 3x3 kernel, 8-bit).
module tb_conv2_core;
   import conv2_pkg::*;

   localparam int unsigned SIZE      = 7;
   localparam int unsigned SIZEKer   = 3;
   localparam int unsigned WIDTH_BIT = 8;
   localparam int unsigned OUT       = 5;
   localparam int unsigned IW        = 3;
   localparam int unsigned OW        = 3;

`ifdef CONV2_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clock;
   logic nreset;

   conv2_if #(.SIZE(SIZE), .SIZEKer(SIZEKer), .WIDTH_BIT(WIDTH_BIT)) bus ();

   conv2_core #(.SIZE(SIZE), .SIZEKer(SIZEKer), .WIDTH_BIT(WIDTH_BIT)) dut (
      .clock  (clock),
      .nreset (nreset),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string name;
      int    kind;   // 0: constant k, 1: ramp 7r+c
      int    k;
      int    r;
      int    c;
      int    exp_w;
      int    exp_s;
   } vec_t;

   vec_t vecs [14];
   int   n_checks;
   int   n_errors;

   function automatic int out_at(input int r, input int c);
      return int'(bus.convIxKernelOut[OW'(r)][OW'(c)]);
   endfunction

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic set_pattern(input int kind, input int k);
      for (int r = 0; r < int'(SIZE); r++) begin
         for (int c = 0; c < int'(SIZE); c++) begin
            bus.inpMatrixI[IW'(r)][IW'(c)] = (kind == 1) ? 8'(7 * r + c) : 8'(k);
         end
      end
   endtask

   // Pulse reset on falling edges; the next rising edge is edge 1 of the run.
   task automatic start_run();
      @(negedge clock);
      nreset = 1'b0;
      @(negedge clock);
      nreset = 1'b1;
   endtask

   task automatic run_edges(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      nreset   = 1'b0;
      set_pattern(0, 0);

      vecs[0]  = '{"zero_00",   0,   0, 0, 0,   0,   0};
      vecs[1]  = '{"zero_44",   0,   0, 4, 4,   0,   0};
      vecs[2]  = '{"ones_00",   0,   1, 0, 0,   9,   9};
      vecs[3]  = '{"ones_23",   0,   1, 2, 3,   9,   9};
      vecs[4]  = '{"ones_44",   0,   1, 4, 4,   9,   9};
      vecs[5]  = '{"ramp_00",   1,   0, 0, 0,  72,  72};
      vecs[6]  = '{"ramp_01",   1,   0, 0, 1,  81,  81};
      vecs[7]  = '{"ramp_10",   1,   0, 1, 0, 135, 135};
      vecs[8]  = '{"ramp_22",   1,   0, 2, 2, 216, 216};
      vecs[9]  = '{"ramp_31",   1,   0, 3, 1,  14, 255};
      vecs[10] = '{"ramp_44",   1,   0, 4, 4, 104, 255};
      vecs[11] = '{"c30_00",    0,  30, 0, 0,  14, 255};
      vecs[12] = '{"c30_44",    0,  30, 4, 4,  14, 255};
      vecs[13] = '{"c255_22",   0, 255, 2, 2, 247, 255};

      repeat (2) @(negedge clock);
      check("reset_done",  int'(bus.done), 0);
      check("reset_out00", out_at(0, 0), 0);
      check("reset_out44", out_at(4, 4), 0);

      foreach (vecs[i]) begin
         set_pattern(vecs[i].kind, vecs[i].k);
         start_run();
         run_edges(25);
         check(vecs[i].name, out_at(vecs[i].r, vecs[i].c), SAT ? vecs[i].exp_s : vecs[i].exp_w);
         check({vecs[i].name, "_done"}, int'(bus.done), 1);
      end

      // done must rise exactly on edge 25
      set_pattern(0, 0);
      start_run();
      for (int e = 1; e <= 25; e++) begin
         run_edges(1);
         check($sformatf("done_edge%0d", e), int'(bus.done), (e == 25) ? 1 : 0);
      end

      // element write latency with all-ones input
      set_pattern(0, 1);
      start_run();
      run_edges(1);
      check("lat_e1_out00", out_at(0, 0), 9);
      check("lat_e1_out01", out_at(0, 1), 0);
      run_edges(23);
      check("lat_e24_out44", out_at(4, 4), 0);
      check("lat_e24_out43", out_at(4, 3), 9);
      run_edges(1);
      check("lat_e25_out44", out_at(4, 4), 9);

      // input changes after done are ignored
      set_pattern(0, 30);
      run_edges(30);
      check("hold_out00", out_at(0, 0), 9);
      check("hold_out23", out_at(2, 3), 9);
      check("hold_out44", out_at(4, 4), 9);
      check("hold_done",  int'(bus.done), 1);

      // asynchronous reset mid-run, then a full clean rerun
      set_pattern(0, 1);
      start_run();
      run_edges(10);
      check("mid_pre_out14", out_at(1, 4), 9);
      #1;
      nreset = 1'b0;
      #1;
      check("async_done",  int'(bus.done), 0);
      check("async_out00", out_at(0, 0), 0);
      check("async_out14", out_at(1, 4), 0);
      @(negedge clock);
      nreset = 1'b1;
      run_edges(24);
      check("rerun_e24_done", int'(bus.done), 0);
      run_edges(1);
      for (int r = 0; r < int'(OUT); r++) begin
         for (int c = 0; c < int'(OUT); c++) begin
            check($sformatf("rerun_out%0d%0d", r, c), out_at(r, c), 9);
         end
      end
      check("rerun_done", int'(bus.done), 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
